ft245_slv_fifo_emu: RTL

//  Synthesizable emulator of the FT600 245-mode synchronous slave FIFO, i.e. the chip
//  end of the bus the master FIFO FSM drives. It answers the master's rd_n/oe_n/wr_n

---
 rtl/ft245_slv_fifo_emu.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ft245_slv_fifo_emu.sv
// ---------------------------------------------------------------------------
// ft245_slv_fifo_emu
//   Emulates the chip end of an FT600 245-mode synchronous slave FIFO bus.
//   The master's wr_n/rd_n/oe_n handshake is answered with txe_n/rxf_n. Read
//   data comes from an RX buffer that the host fills, and write data lands in
//   a TX buffer that the host drains. Intended for on-board loopback and for
//   closed-loop simulation of a master FIFO FSM without FT600 silicon.
//
// Parameters
//   DEPTH_LOG2   log2 of the entry count of each buffer (entries are 36 bits)
//   TXE_MARGIN   txe_n rises once TX free entries <= TXE_MARGIN, leaving room
//                for writes already in the master's pipeline
//
// Ports
//   clk, rst_n          bus clock; asynchronous active-low reset
//   wr_n, rd_n, oe_n    master strobes, active low
//   mdata, mbe          master write data / byte enables
//   txe_n, rxf_n        TX can accept / RX holds data, active low, registered
//   sdata, sbe          RX buffer head (all ones when empty)
//   s_oe                pad tristate enable for sdata/sbe, registered
//   h_rx_wr, h_rx_dat   host push into RX buffer ({be,data})
//   h_rx_full           RX buffer full; host pushes while full are dropped
//   h_tx_rd             host pop of the TX buffer head
//   h_tx_dat            TX buffer head, show-ahead (zero when empty)
//   h_tx_nempt          TX buffer not empty
//   clr_err             synchronous clear of the sticky error flags
//   wr_overrun          sticky: master write arrived while TX buffer full
//   rd_underrun         sticky: rd_n low in a read state with rxf_n high
//   bus_err             sticky: oe_n and wr_n low together
// ---------------------------------------------------------------------------
module ft245_slv_fifo_emu #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TXE_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_n,
  input  logic        rd_n,
  input  logic        oe_n,
  input  logic [31:0] mdata,
  input  logic [3:0]  mbe,
  output logic        txe_n,
  output logic        rxf_n,
  output logic [31:0] sdata,
  output logic [3:0]  sbe,
  output logic        s_oe,
  input  logic        h_rx_wr,
  input  logic [35:0] h_rx_dat,
  output logic        h_rx_full,
  input  logic        h_tx_rd,
  output logic [35:0] h_tx_dat,
  output logic        h_tx_nempt,
  input  logic        clr_err,
  output logic        wr_overrun,
  output logic        rd_underrun,
  output logic        bus_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    RD_TURN  = 4'b0010,
    RD_BURST = 4'b0100,
    WR_BURST = 4'b1000
  } state_t;

  state_t state;

  logic [35:0]   rx_mem [DEPTH];
  logic [35:0]   tx_mem [DEPTH];
  logic [PW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [PW-1:0] rx_wp_nxt, rx_rp_nxt, tx_wp_nxt, tx_rp_nxt;
  logic [PW-1:0] tx_cnt_nxt, tx_free_nxt;

  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rd_state, wr_state;
  logic rx_push, rx_pop, tx_req, tx_push, tx_pop;
  logic under_ev, over_ev, bus_ev;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[PW-1] != rx_rp[PW-1]) && (rx_wp[PW-2:0] == rx_rp[PW-2:0]);
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[PW-1] != tx_rp[PW-1]) && (tx_wp[PW-2:0] == tx_rp[PW-2:0]);

  assign rd_state = (state == RD_TURN) || (state == RD_BURST);
  assign wr_state = (state == IDLE) || (state == WR_BURST);

  assign rx_pop   = !rd_n && !rxf_n && rd_state;
  assign under_ev = !rd_n &&  rxf_n && rd_state;
  assign rx_push  = h_rx_wr && !rx_full;

  // Master writes land whenever there is room, even after txe_n has risen.
  assign tx_req   = !wr_n && wr_state;
  assign tx_push  = tx_req && !tx_full;
  assign over_ev  = tx_req && tx_full;
  assign tx_pop   = h_tx_rd && !tx_empty;

  assign bus_ev   = !oe_n && !wr_n;

  assign rx_wp_nxt   = rx_wp + {{(PW-1){1'b0}}, rx_push};
  assign rx_rp_nxt   = rx_rp + {{(PW-1){1'b0}}, rx_pop};
  assign tx_wp_nxt   = tx_wp + {{(PW-1){1'b0}}, tx_push};
  assign tx_rp_nxt   = tx_rp + {{(PW-1){1'b0}}, tx_pop};
  assign tx_cnt_nxt  = tx_wp_nxt - tx_rp_nxt;
  assign tx_free_nxt = PW'(DEPTH) - tx_cnt_nxt;

  // Head words are show-ahead, so a pop edge moves sdata to the next word
  // while the master captures the popped one.
  assign {sbe, sdata} = rx_empty ? 36'hF_FFFF_FFFF : rx_mem[rx_rp[PW-2:0]];
  assign h_tx_dat     = tx_empty ? 36'h0 : tx_mem[tx_rp[PW-2:0]];
  assign h_rx_full    = rx_full;
  assign h_tx_nempt   = !tx_empty;

  // Buffer storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[PW-2:0]] <= h_rx_dat;
    if (tx_push) tx_mem[tx_wp[PW-2:0]] <= {mbe, mdata};
  end

  // Pointers plus the registered flow-control flags, which look at the
  // occupancy after this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp <= '0;
      rx_rp <= '0;
      tx_wp <= '0;
      tx_rp <= '0;
      rxf_n <= 1'b1;
      txe_n <= 1'b1;
    end else begin
      rx_wp <= rx_wp_nxt;
      rx_rp <= rx_rp_nxt;
      tx_wp <= tx_wp_nxt;
      tx_rp <= tx_rp_nxt;
      rxf_n <= (rx_wp_nxt == rx_rp_nxt);
      txe_n <= (tx_free_nxt <= PW'(TXE_MARGIN));
    end
  end

  // Bus FSM with registered s_oe and sticky error flags. A simultaneous
  // oe_n/wr_n assertion is treated as a write so the slave never drives
  // the pads against the master.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      s_oe        <= 1'b0;
      wr_overrun  <= 1'b0;
      rd_underrun <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      s_oe <= rd_state && !oe_n && wr_n;

      if (bus_ev) begin
        state <= WR_BURST;
      end else begin
        unique case (state)
          IDLE: begin
            if (!wr_n)      state <= WR_BURST;
            else if (!oe_n) state <= RD_TURN;
          end
          RD_TURN: begin
            if (oe_n)       state <= IDLE;
            else if (!rd_n) state <= RD_BURST;
          end
          RD_BURST: begin
            if (oe_n)       state <= IDLE;
          end
          WR_BURST: begin
            if (wr_n)       state <= IDLE;
          end
          default:          state <= IDLE;
        endcase
      end

      if (over_ev)      wr_overrun <= 1'b1;
      else if (clr_err) wr_overrun <= 1'b0;

      if (under_ev)     rd_underrun <= 1'b1;
      else if (clr_err) rd_underrun <= 1'b0;

      if (bus_ev)       bus_err <= 1'b1;
      else if (clr_err) bus_err <= 1'b0;
    end
  end

endmodule
